// File: rtl/fir_result_sink.sv
// fir_result_sink: requantizes signed filter output to 8 bits (arithmetic
// shift plus saturation) and buffers the result in a small FIFO with a
// valid/ready consumer port, occupancy output and sticky saturate/drop flags.
// Build option: define FIR_SINK_ROUND_EN for round-half-up before the shift;
// without it the shift truncates toward minus infinity.
module fir_result_sink #(
   parameter int IN_W  = 18,
   parameter int SHIFT = 7,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [IN_W-1:0]    y_in,
   input  logic                      in_valid,
   output logic signed [7:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      sat_flag,
   output logic                      drop_flag,
   input  logic                      clr_flags
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'(127);
   localparam logic signed [IN_W:0] Q_MIN = ~Q_MAX;  // -128
`ifdef FIR_SINK_ROUND_EN
   localparam logic signed [IN_W:0] RND_K = (IN_W+1)'(1) << (SHIFT - 1);
`endif

   // Datapath signals
   logic signed [IN_W:0] y_ext;
   logic signed [IN_W:0] y_adj;
   logic signed [IN_W:0] q_full;
   logic signed [7:0]    q8;
   logic                 q_sat;

   // Control signals
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 do_push;
   logic                 do_pop;
   logic                 do_drop;

   // State
   logic signed [7:0]    mem_q [DEPTH];
   logic signed [7:0]    mem_d [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 sat_q, sat_d;
   logic                 drop_q, drop_d;

   // Requantize: sign-extend by one bit, optionally round, shift, saturate
   always_comb begin
      y_ext = {y_in[IN_W-1], y_in};
`ifdef FIR_SINK_ROUND_EN
      y_adj = y_ext + RND_K;
`else
      y_adj = y_ext;
`endif
      q_full = y_adj >>> SHIFT;
      q_sat  = 1'b0;
      q8     = q_full[7:0];
      if (q_full > Q_MAX) begin
         q8    = 8'sd127;
         q_sat = 1'b1;
      end else if (q_full < Q_MIN) begin
         q8    = -8'sd128;
         q_sat = 1'b1;
      end
   end

   // FIFO control: a pop on the same edge frees the slot for a push when full
   always_comb begin
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == LW'(DEPTH));
      do_pop     = !fifo_empty && out_ready;
      do_push    = in_valid && (!fifo_full || do_pop);
      do_drop    = in_valid && fifo_full && !do_pop;
   end

   // Next-state for storage, pointers, occupancy and sticky flags
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      sat_d    = sat_q;
      drop_d   = drop_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = q8;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (do_push && q_sat) begin
         sat_d = 1'b1;
      end
      if (do_drop) begin
         drop_d = 1'b1;
      end
      if (clr_flags) begin
         sat_d  = 1'b0;
         drop_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sat_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sat_q    <= sat_d;
         drop_q   <= drop_d;
      end
   end

   // Outputs are decoded from registers only, so reset clears them at once
   always_comb begin
      out_valid = !fifo_empty;
      out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
      level     = level_q;
      sat_flag  = sat_q;
      drop_flag = drop_q;
   end

endmodule

// File: tb/tb_fir_result_sink.sv
// Directed testbench for fir_result_sink with default parameters
// (IN_W=18, SHIFT=7, DEPTH=4). Expected values are hand-computed.
module tb_fir_result_sink;

   logic               clk;
   logic               reset;
   logic signed [17:0] y_in;
   logic               in_valid;
   logic signed [7:0]  out_data;
   logic               out_valid;
   logic               out_ready;
   logic [2:0]         level;
   logic               sat_flag;
   logic               drop_flag;
   logic               clr_flags;

   int pass_cnt = 0;
   int total_cnt = 0;

   fir_result_sink #(.IN_W(18), .SHIFT(7), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .y_in      (y_in),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .sat_flag  (sat_flag),
      .drop_flag (drop_flag),
      .clr_flags (clr_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helper: present one sample for one edge, sample 1ns after it
   task automatic push_one(input logic signed [17:0] v);
      y_in     = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; y_in = '0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      #2;
      total_cnt++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'sd0) begin
         $display("FAIL reset_outputs: got valid=%0b level=%0d data=%0d, want 0/0/0", out_valid, level, out_data);
      end else pass_cnt++;
      total_cnt++;
      if (sat_flag !== 1'b0 || drop_flag !== 1'b0) begin
         $display("FAIL reset_flags: got sat=%0b drop=%0b, want 0/0", sat_flag, drop_flag);
      end else pass_cnt++;
      @(posedge clk);
      #2;
      reset = 1'b1;
      // first edge after release must accept a push: 256>>>7 = 2
      push_one(18'sd256);
      total_cnt++;
      if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== 8'sd2) begin
         $display("FAIL first_push: got valid=%0b level=%0d data=%0d, want 1/1/2", out_valid, level, out_data);
      end else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'sd0) begin
         $display("FAIL empty_data_zero: got valid=%0b level=%0d data=%0d, want 0/0/0", out_valid, level, out_data);
      end else pass_cnt++;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      push_one(18'sd1280);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 8'sd10 || level !== 3'd1) begin
         $display("FAIL basic_push: got valid=%0b data=%0d level=%0d, want 1/10/1", out_valid, out_data, level);
      end else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (level !== 3'd0 || out_valid !== 1'b0) begin
         $display("FAIL basic_pop: got level=%0d valid=%0b, want 0/0", level, out_valid);
      end else pass_cnt++;
      // pop request on an empty FIFO must not underflow
      @(posedge clk);
      #1;
      total_cnt++;
      if (level !== 3'd0) begin
         $display("FAIL empty_pop: got level=%0d, want 0", level);
      end else pass_cnt++;
      out_ready = 1'b0;
   endtask

   task automatic test_saturation;
      out_ready = 1'b0;
      push_one(18'sd20000);
      push_one(-18'sd20000);
      total_cnt++;
      if (out_data !== 8'sd127 || level !== 3'd2 || sat_flag !== 1'b1) begin
         $display("FAIL sat_pos: got data=%0d level=%0d sat=%0b, want 127/2/1", out_data, level, sat_flag);
      end else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out_data !== 8'sd127) begin
         $display("FAIL hold_stable: got data=%0d, want 127", out_data);
      end else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out_data !== -8'sd128 || level !== 3'd1) begin
         $display("FAIL sat_neg: got data=%0d level=%0d, want -128/1", out_data, level);
      end else pass_cnt++;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      clr_flags = 1'b1;
      @(posedge clk);
      #1;
      clr_flags = 1'b0;
      total_cnt++;
      if (sat_flag !== 1'b0 || level !== 3'd0) begin
         $display("FAIL sat_clear: got sat=%0b level=%0d, want 0/0", sat_flag, level);
      end else pass_cnt++;
      // clear wins over a same-edge saturating push
      clr_flags = 1'b1;
      push_one(18'sd20000);
      clr_flags = 1'b0;
      total_cnt++;
      if (sat_flag !== 1'b0 || level !== 3'd1) begin
         $display("FAIL clr_priority: got sat=%0b level=%0d, want 0/1", sat_flag, level);
      end else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_rounding;
      logic signed [7:0] exp_a;
      logic signed [7:0] exp_b;
`ifdef FIR_SINK_ROUND_EN
      exp_a = 8'sd2;
      exp_b = -8'sd1;
`else
      exp_a = 8'sd1;
      exp_b = -8'sd2;
`endif
      out_ready = 1'b0;
      push_one(18'sd192);
      push_one(-18'sd192);
      total_cnt++;
      if (out_data !== exp_a || sat_flag !== 1'b0) begin
         $display("FAIL round_pos: got data=%0d sat=%0b, want %0d/0", out_data, sat_flag, exp_a);
      end else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out_data !== exp_b) begin
         $display("FAIL round_neg: got data=%0d, want %0d", out_data, exp_b);
      end else pass_cnt++;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_overflow;
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) push_one(18'(128 * k));
      total_cnt++;
      if (level !== 3'd4 || drop_flag !== 1'b1 || out_data !== 8'sd1) begin
         $display("FAIL overflow_state: got level=%0d drop=%0b data=%0d, want 4/1/1", level, drop_flag, out_data);
      end else pass_cnt++;
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         total_cnt++;
         if (out_data !== 8'(k) || out_valid !== 1'b1) begin
            $display("FAIL overflow_drain%0d: got data=%0d valid=%0b, want %0d/1", k, out_data, out_valid, k);
         end else pass_cnt++;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      total_cnt++;
      if (level !== 3'd0 || out_valid !== 1'b0) begin
         $display("FAIL overflow_empty: got level=%0d valid=%0b, want 0/0", level, out_valid);
      end else pass_cnt++;
      clr_flags = 1'b1;
      @(posedge clk);
      #1;
      clr_flags = 1'b0;
      total_cnt++;
      if (drop_flag !== 1'b0) begin
         $display("FAIL drop_clear: got drop=%0b, want 0", drop_flag);
      end else pass_cnt++;
   endtask

   task automatic test_full_push_pop;
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) push_one(18'(128 * k));
      out_ready = 1'b1;
      push_one(18'sd640);
      total_cnt++;
      if (level !== 3'd4 || drop_flag !== 1'b0 || out_data !== 8'sd2) begin
         $display("FAIL full_push_pop: got level=%0d drop=%0b data=%0d, want 4/0/2", level, drop_flag, out_data);
      end else pass_cnt++;
      for (int k = 2; k <= 5; k++) begin
         total_cnt++;
         if (out_data !== 8'(k)) begin
            $display("FAIL full_order%0d: got data=%0d, want %0d", k, out_data, k);
         end else pass_cnt++;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      total_cnt++;
      if (level !== 3'd0) begin
         $display("FAIL full_drained: got level=%0d, want 0", level);
      end else pass_cnt++;
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b0;
      push_one(18'sd128);
      push_one(18'sd256);
      push_one(18'sd384);
      total_cnt++;
      if (level !== 3'd3) begin
         $display("FAIL mid_prefill: got level=%0d, want 3", level);
      end else pass_cnt++;
      #3;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'sd0) begin
         $display("FAIL mid_reset_async: got valid=%0b level=%0d data=%0d, want 0/0/0", out_valid, level, out_data);
      end else pass_cnt++;
      #2;
      reset = 1'b1;
      push_one(18'sd896);
      total_cnt++;
      if (out_data !== 8'sd7 || level !== 3'd1 || out_valid !== 1'b1) begin
         $display("FAIL mid_first_out: got data=%0d level=%0d valid=%0b, want 7/1/1", out_data, level, out_valid);
      end else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_saturation;
      test_rounding;
      test_overflow;
      test_full_push_pop;
      test_reset_midstream;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
